// File: rtl/rename_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rename_pkg
//  Description : Constants and types shared by the rename stage, the RAT,
//                commit and the physical-register free list.
//  Revision    : 1.0  initial release
// ============================================================================
package rename_pkg;

    localparam int NUM_ARCH_REGS = 32;
    localparam int NUM_PRF       = 128;
    localparam int PRF_W         = 8;

    // IDs above the architectural identity mapping start out free
    localparam int FL_DEPTH      = NUM_PRF - NUM_ARCH_REGS;
    localparam int FL_PTR_W      = $clog2(FL_DEPTH);
    localparam int FL_CNT_W      = $clog2(FL_DEPTH + 1);

    typedef logic [PRF_W-1:0] prf_id_t;

endpackage
`default_nettype wire

// File: rtl/prf_free_list_if.sv
`default_nettype none
// ============================================================================
//  Module      : prf_free_list_if
//  Description : Allocate / release handshake between rename, commit and
//                the physical-register free list.
//  Revision    : 1.0  initial release
// ============================================================================
interface prf_free_list_if #(
    parameter int PRF_W = rename_pkg::PRF_W,
    parameter int CNT_W = rename_pkg::FL_CNT_W
) ();

    logic             Alloc_Req;
    logic [PRF_W-1:0] Allocated_PRF_ID;
    logic             Alloc_Grant;
    logic             Empty;
    logic             Free_Valid;
    logic [PRF_W-1:0] Freed_PRF_ID;
    logic [CNT_W-1:0] Free_Count;
    logic             Overflow;

    // rename/commit side
    modport master (
        output Alloc_Req, Free_Valid, Freed_PRF_ID,
        input  Allocated_PRF_ID, Alloc_Grant, Empty, Free_Count, Overflow
    );

    // free-list side
    modport slave (
        input  Alloc_Req, Free_Valid, Freed_PRF_ID,
        output Allocated_PRF_ID, Alloc_Grant, Empty, Free_Count, Overflow
    );

endinterface
`default_nettype wire

// File: rtl/prf_free_list.sv
`default_nettype none
// ============================================================================
//  Module      : prf_free_list
//  Description : Circular FIFO of free physical-register IDs. Head feeds the
//                RAT with zero-latency allocation; commit releases old
//                mappings at the tail. x0 releases are filtered out and a
//                release into a full list raises a sticky Overflow.
//  Revision    : 1.0  initial release
// ============================================================================
module prf_free_list #(
    parameter int NUM_ARCH_REGS = rename_pkg::NUM_ARCH_REGS,
    parameter int NUM_PRF       = rename_pkg::NUM_PRF,
    parameter int PRF_W         = rename_pkg::PRF_W,
    parameter int DEPTH         = NUM_PRF - NUM_ARCH_REGS
) (
    input  wire logic          CLK,
    input  wire logic          Reset,
    prf_free_list_if.slave     fl
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PRF_W-1:0] mem_q [DEPTH];
    logic [PRF_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    logic             grant;
    logic             do_free;
    logic             free_nz;

    // Pointers wrap explicitly because DEPTH need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Grant/free decisions and next-state; no free-to-alloc bypass when empty
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        // grant is held low while reset is asserted
        grant   = Reset && fl.Alloc_Req && (count_q != '0);
        // x0's mapping is never recycled, so a zero ID is not a release at all
        free_nz = fl.Free_Valid && (fl.Freed_PRF_ID != '0);
        // fullness is judged on the pre-edge count: a same-cycle grant does not make room
        do_free = free_nz && (count_q != CNT_FULL);

        if (grant) begin
            head_d = ptr_inc(head_q);
        end
        if (do_free) begin
            mem_d[tail_q] = fl.Freed_PRF_ID;
            tail_d        = ptr_inc(tail_q);
        end
        if (free_nz && (count_q == CNT_FULL)) begin
            ovf_d = 1'b1;
        end

        if (grant && !do_free) begin
            count_d = count_q - 1'b1;
        end else if (do_free && !grant) begin
            count_d = count_q + 1'b1;
        end
    end

    // State register; reset reloads the free IDs above the identity mapping
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= PRF_W'(NUM_ARCH_REGS + i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CNT_FULL;
            ovf_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign fl.Allocated_PRF_ID = mem_q[head_q];
    assign fl.Alloc_Grant      = grant;
    assign fl.Empty            = (count_q == '0);
    assign fl.Free_Count       = count_q;
    assign fl.Overflow         = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_prf_free_list.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prf_free_list
//  Description : Self-checking bench for prf_free_list against a queue model
//                of the free pool.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_prf_free_list;
    import rename_pkg::*;

    localparam int DEPTH = FL_DEPTH;

    logic CLK;
    logic Reset;

    prf_free_list_if fl_if ();

    prf_free_list dut (
        .CLK   (CLK),
        .Reset (Reset),
        .fl    (fl_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // model: free IDs in allocation order, plus the sticky error flag
    int fq[$];
    bit m_ovf;

    // values sampled just before the edge, and the model's prediction for them
    logic    s_grant;
    prf_id_t s_id;
    logic    e_grant;
    int      e_id;

    // Drive one cycle, sample pre-edge outputs, then advance the model
    task automatic cycle(input bit rn, input bit req, input bit fv, input int id);
        int n;
        @(negedge CLK);
        Reset              = rn;
        fl_if.Alloc_Req    = req;
        fl_if.Free_Valid   = fv;
        fl_if.Freed_PRF_ID = prf_id_t'(id);
        #1;
        s_grant = fl_if.Alloc_Grant;
        s_id    = fl_if.Allocated_PRF_ID;
        e_grant = rn && req && (fq.size() > 0);
        e_id    = (fq.size() > 0) ? fq[0] : 0;
        @(posedge CLK);
        if (!rn) begin
            fq.delete();
            for (int i = 0; i < DEPTH; i++) fq.push_back(NUM_ARCH_REGS + i);
            m_ovf = 1'b0;
        end else begin
            n = fq.size();
            if (e_grant) void'(fq.pop_front());
            if (fv && id != 0) begin
                if (n < DEPTH) fq.push_back(id);
                else           m_ovf = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(0, 1, 1, 5);
        checks++;
        if (s_grant !== 1'b0) begin
            errors++; $display("FAIL reset_grant: got %b want 0", s_grant);
        end
        cycle(0, 1, 0, 0);
        checks++;
        if (fl_if.Free_Count !== FL_CNT_W'(96) || fl_if.Empty !== 1'b0 ||
            fl_if.Overflow !== 1'b0 || fl_if.Allocated_PRF_ID !== prf_id_t'(32)) begin
            errors++;
            $display("FAIL reset_state: cnt=%0d empty=%b ovf=%b id=%0d want 96/0/0/32",
                     fl_if.Free_Count, fl_if.Empty, fl_if.Overflow, fl_if.Allocated_PRF_ID);
        end
    endtask

    task automatic test_alloc3();
        for (int k = 0; k < 3; k++) begin
            cycle(1, 1, 0, 0);
            checks++;
            if (s_grant !== 1'b1 || s_id !== prf_id_t'(32 + k)) begin
                errors++; $display("FAIL alloc3_id: grant=%b id=%0d want 1/%0d", s_grant, s_id, 32 + k);
            end
        end
        checks++;
        if (fl_if.Free_Count !== FL_CNT_W'(93) || fl_if.Empty !== 1'b0) begin
            errors++; $display("FAIL alloc3_count: cnt=%0d empty=%b want 93/0", fl_if.Free_Count, fl_if.Empty);
        end
    endtask

    task automatic test_drain();
        prf_id_t last = '0;
        for (int k = 0; k < 93; k++) begin
            cycle(1, 1, 0, 0);
            checks++;
            if (s_grant !== e_grant || s_id !== prf_id_t'(e_id)) begin
                errors++; $display("FAIL drain_seq: grant=%b id=%0d want %b/%0d", s_grant, s_id, e_grant, e_id);
            end
            last = s_id;
        end
        checks++;
        if (last !== prf_id_t'(127) || fl_if.Empty !== 1'b1 || fl_if.Free_Count !== '0) begin
            errors++; $display("FAIL drain_end: last=%0d empty=%b cnt=%0d want 127/1/0", last, fl_if.Empty, fl_if.Free_Count);
        end
        cycle(1, 1, 0, 0);
        checks++;
        if (s_grant !== 1'b0) begin
            errors++; $display("FAIL drain_97th: grant=%b want 0", s_grant);
        end
    endtask

    task automatic test_empty_free();
        cycle(1, 1, 1, 40);
        checks++;
        if (s_grant !== 1'b0 || fl_if.Free_Count !== FL_CNT_W'(1)) begin
            errors++; $display("FAIL empty_nobypass: grant=%b cnt=%0d want 0/1", s_grant, fl_if.Free_Count);
        end
        cycle(1, 1, 0, 0);
        checks++;
        if (s_grant !== 1'b1 || s_id !== prf_id_t'(40) || fl_if.Empty !== 1'b1) begin
            errors++; $display("FAIL empty_next: grant=%b id=%0d empty=%b want 1/40/1", s_grant, s_id, fl_if.Empty);
        end
    endtask

    task automatic test_back_to_back();
        int n7 = 0;
        cycle(0, 0, 0, 0);
        for (int k = 0; k < 5; k++) cycle(1, 1, 0, 0);
        for (int k = 0; k < 100; k++) begin
            cycle(1, 1, 1, 7);
            if (s_id === prf_id_t'(7)) n7++;
            checks++;
            if (s_grant !== 1'b1 || s_id !== prf_id_t'(e_id) || fl_if.Free_Count !== FL_CNT_W'(91)) begin
                errors++;
                $display("FAIL b2b_cycle%0d: grant=%b id=%0d cnt=%0d want 1/%0d/91",
                         k, s_grant, s_id, fl_if.Free_Count, e_id);
            end
        end
        // 7s written at slots 0..8 are reached once head wraps past 95
        checks++;
        if (n7 != 9) begin
            errors++; $display("FAIL b2b_reuse7: got %0d grants of 7 want 9", n7);
        end
    endtask

    task automatic test_overflow();
        cycle(0, 0, 0, 0);
        cycle(1, 0, 1, 50);
        checks++;
        if (fl_if.Overflow !== 1'b1 || fl_if.Free_Count !== FL_CNT_W'(96)) begin
            errors++; $display("FAIL ovf_set: ovf=%b cnt=%0d want 1/96", fl_if.Overflow, fl_if.Free_Count);
        end
        for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0);
        checks++;
        if (fl_if.Overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky: ovf=%b want 1", fl_if.Overflow);
        end
        cycle(1, 1, 0, 0);
        cycle(1, 0, 1, 0);
        checks++;
        if (fl_if.Free_Count !== FL_CNT_W'(95) || fl_if.Allocated_PRF_ID !== prf_id_t'(33)) begin
            errors++; $display("FAIL free_x0: cnt=%0d id=%0d want 95/33", fl_if.Free_Count, fl_if.Allocated_PRF_ID);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 4; k++) cycle(1, 1, 1, 60 + k);
        cycle(0, 1, 1, 9);
        checks++;
        if (s_grant !== 1'b0 || fl_if.Free_Count !== FL_CNT_W'(96) ||
            fl_if.Allocated_PRF_ID !== prf_id_t'(32) || fl_if.Overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: grant=%b cnt=%0d id=%0d ovf=%b want 0/96/32/0",
                     s_grant, fl_if.Free_Count, fl_if.Allocated_PRF_ID, fl_if.Overflow);
        end
    endtask

    task automatic test_random();
        bit rn, req, fv;
        int id;
        for (int k = 0; k < 600; k++) begin
            rn  = ($urandom % 80) != 0;
            req = ($urandom % 4) != 0;
            fv  = ($urandom % 3) != 0;
            id  = (($urandom % 16) == 0) ? 0 : int'($urandom_range(1, 127));
            cycle(rn, req, fv, id);
            checks++;
            if (s_grant !== e_grant || (e_grant && s_id !== prf_id_t'(e_id)) ||
                fl_if.Free_Count !== FL_CNT_W'(fq.size()) || fl_if.Empty !== (fq.size() == 0) ||
                fl_if.Overflow !== m_ovf || (fq.size() > 0 && fl_if.Allocated_PRF_ID !== prf_id_t'(fq[0]))) begin
                errors++;
                $display("FAIL random_%0d: grant=%b id=%0d cnt=%0d ovf=%b want %b/%0d/%0d/%b",
                         k, s_grant, s_id, fl_if.Free_Count, fl_if.Overflow,
                         e_grant, e_id, fq.size(), m_ovf);
            end
        end
    endtask

    initial begin
        Reset              = 1'b0;
        fl_if.Alloc_Req    = 1'b0;
        fl_if.Free_Valid   = 1'b0;
        fl_if.Freed_PRF_ID = '0;
        m_ovf              = 1'b0;
        test_reset();
        test_alloc3();
        test_drain();
        test_empty_free();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
